// File: rtl/rr_arbiter_pkg.sv
// Shared types and bit-vector helpers for the round-robin arbiter.
// Helpers work on MAX_W-bit vectors; callers zero-extend and truncate to their own WIDTH.
package rr_arbiter_pkg;

  localparam int MAX_W     = 64;
  localparam int MAX_IDX_W = 6;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

  // Fill every bit at or below the highest set bit of the priority vector.
  function automatic logic [MAX_W-1:0] pry2thr(input logic [MAX_W-1:0] pry);
    logic [MAX_W-1:0] thr;
    thr[MAX_W-1] = pry[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      thr[i] = thr[i+1] | pry[i];
    end
    return thr;
  endfunction

  // Fill every bit at or above the lowest set bit; thr2oht of this isolates that bit.
  function automatic logic [MAX_W-1:0] low2thr(input logic [MAX_W-1:0] vec);
    logic [MAX_W-1:0] thr;
    thr[0] = vec[0];
    for (int i = 1; i < MAX_W; i++) begin
      thr[i] = thr[i-1] | vec[i];
    end
    return thr;
  endfunction

  function automatic logic [MAX_W-1:0] thr2oht(input logic [MAX_W-1:0] thr);
    return thr & ~(thr << 1);
  endfunction

  function automatic logic [MAX_IDX_W-1:0] oht2idx(input logic [MAX_W-1:0] oht);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (oht[i]) idx = idx | MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter_thr_mask_select.sv
// Round-robin pick: lowest requester above the last grant, else lowest overall.
module rr_mask_select #(
  parameter  int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req_eff,
  input  logic [WIDTH-1:0] ptr_oht,
  output logic             sel_vld,
  output logic [WIDTH-1:0] sel_oht,
  output logic [IDX_W-1:0] sel_idx
);
  import rr_arbiter_pkg::*;

  logic [WIDTH-1:0] thr;
  logic [WIDTH-1:0] msk;
  logic [WIDTH-1:0] req_msk;
  logic [WIDTH-1:0] cand;

  // Falling back to the unmasked vector gives the wrap from WIDTH-1 to 0.
  always_comb begin
    thr     = WIDTH'(pry2thr(MAX_W'(ptr_oht)));
    msk     = ~thr;
    req_msk = req_eff & msk;
    cand    = (|req_msk) ? req_msk : req_eff;
    sel_oht = WIDTH'(thr2oht(low2thr(MAX_W'(cand))));
    sel_idx = IDX_W'(oht2idx(MAX_W'(sel_oht)));
    sel_vld = |req_eff;
  end

endmodule

// File: rtl/rr_arbiter_thr.sv
// Registered round-robin arbiter with valid/ready on every requester and on the grant port.
module rr_arbiter_thr #(
  parameter  int WIDTH  = 8,
  parameter  int DATA_W = 8,
  localparam int IDX_W  = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  req_vld,
  input  logic [DATA_W-1:0] req_dat [WIDTH],
  output logic [WIDTH-1:0]  req_rdy,
  output logic              gnt_vld,
  input  logic              gnt_rdy,
  output logic [WIDTH-1:0]  gnt_oht,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic [DATA_W-1:0] gnt_dat
);
  import rr_arbiter_pkg::*;

  localparam logic [WIDTH-1:0] PTR_RST = {1'b1, {(WIDTH-1){1'b0}}};

  slot_e             slot_q, slot_d;
  logic [WIDTH-1:0]  gnt_oht_q, gnt_oht_d;
  logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
  logic [DATA_W-1:0] gnt_dat_q, gnt_dat_d;
  logic [WIDTH-1:0]  ptr_oht_q, ptr_oht_d;

  logic              trn;
  logic              load;
  logic [WIDTH-1:0]  req_eff;
  logic              sel_vld;
  logic [WIDTH-1:0]  sel_oht;
  logic [IDX_W-1:0]  sel_idx;
  logic [DATA_W-1:0] sel_dat;

  assign gnt_vld = (slot_q == SLOT_FULL);
  assign gnt_oht = gnt_oht_q;
  assign gnt_idx = gnt_idx_q;
  assign gnt_dat = gnt_dat_q;

  assign trn     = gnt_vld & gnt_rdy;
  assign load    = !gnt_vld | trn;
  assign req_rdy = gnt_oht_q & {WIDTH{gnt_rdy}};
  // The requester transferring now still shows valid for the item leaving; keep it out of the pick.
  assign req_eff = req_vld & ~(gnt_oht_q & {WIDTH{trn}});

  rr_mask_select #(
    .WIDTH (WIDTH)
  ) u_mask_select (
    .req_eff (req_eff),
    .ptr_oht (ptr_oht_q),
    .sel_vld (sel_vld),
    .sel_oht (sel_oht),
    .sel_idx (sel_idx)
  );

  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sel_dat = sel_dat | (req_dat[i] & {DATA_W{sel_oht[i]}});
    end
  end

  always_comb begin
    slot_d    = slot_q;
    gnt_oht_d = gnt_oht_q;
    gnt_idx_d = gnt_idx_q;
    gnt_dat_d = gnt_dat_q;
    ptr_oht_d = ptr_oht_q;
    if (load) begin
      if (sel_vld) begin
        slot_d    = SLOT_FULL;
        gnt_oht_d = sel_oht;
        gnt_idx_d = sel_idx;
        gnt_dat_d = sel_dat;
        ptr_oht_d = sel_oht;
      end else begin
        slot_d    = SLOT_EMPTY;
        gnt_oht_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q    <= SLOT_EMPTY;
      gnt_oht_q <= '0;
      gnt_idx_q <= '0;
      gnt_dat_q <= '0;
      ptr_oht_q <= PTR_RST;
    end else begin
      slot_q    <= slot_d;
      gnt_oht_q <= gnt_oht_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_dat_q <= gnt_dat_d;
      ptr_oht_q <= ptr_oht_d;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_thr.sv
// Directed self-checking bench for rr_arbiter_thr with four requesters.
module tb_rr_arbiter_thr;

  logic       clk;
  logic       rst;
  logic [3:0] req_vld;
  logic [7:0] req_dat [4];
  logic [3:0] req_rdy;
  logic       gnt_vld;
  logic       gnt_rdy;
  logic [3:0] gnt_oht;
  logic [1:0] gnt_idx;
  logic [7:0] gnt_dat;

  int errors;
  int checks;
  int cnt [4];

  rr_arbiter_thr #(
    .WIDTH  (4),
    .DATA_W (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req_vld (req_vld),
    .req_dat (req_dat),
    .req_rdy (req_rdy),
    .gnt_vld (gnt_vld),
    .gnt_rdy (gnt_rdy),
    .gnt_oht (gnt_oht),
    .gnt_idx (gnt_idx),
    .gnt_dat (gnt_dat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are observed 1-2 time units after the rising edge, well clear of both edges.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    req_vld = 4'b0000;
    gnt_rdy = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    req_vld = 4'b1111;
    gnt_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cnt[i]     = 0;
      req_dat[i] = 8'(8'h80 + i * 16);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      settle();
      checks++;
      if (gnt_vld !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_gnt_vld cyc=%0d: got %b expected 0", c, gnt_vld);
      end
      checks++;
      if (req_rdy !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL reset_req_rdy cyc=%0d: got %b expected 0000", c, req_rdy);
      end
    end
    rst = 1'b0;
    tick();
    settle();
    checks++;
    if (gnt_vld !== 1'b1 || gnt_idx !== 2'd0 || gnt_oht !== 4'b0001 || gnt_dat !== 8'h80) begin
      errors++;
      $display("[TB] FAIL first_grant: got vld=%b idx=%0d oht=%b dat=%h expected vld=1 idx=0 oht=0001 dat=80",
               gnt_vld, gnt_idx, gnt_oht, gnt_dat);
    end
  endtask

  task automatic test_round_robin();
    int exp;
    for (int k = 0; k < 6; k++) begin
      exp = k % 4;
      settle();
      checks++;
      if (gnt_vld !== 1'b1 || gnt_idx !== 2'(exp) || gnt_dat !== 8'(8'h80 + exp * 16 + cnt[exp])) begin
        errors++;
        $display("[TB] FAIL rr_grant k=%0d: got vld=%b idx=%0d dat=%h expected vld=1 idx=%0d dat=%h",
                 k, gnt_vld, gnt_idx, gnt_dat, exp, 8'(8'h80 + exp * 16 + cnt[exp]));
      end
      checks++;
      if (req_rdy !== (4'b0001 << exp)) begin
        errors++;
        $display("[TB] FAIL rr_req_rdy k=%0d: got %b expected %b", k, req_rdy, 4'b0001 << exp);
      end
      if (k < 5) begin
        tick();
        cnt[exp]++;
        req_dat[exp] = 8'(8'h80 + exp * 16 + cnt[exp]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req_vld    = 4'b0010;
    req_dat[1] = 8'h5A;
    req_dat[0] = 8'h3C;
    gnt_rdy    = 1'b0;
    tick();
    for (int s = 0; s < 5; s++) begin
      settle();
      checks++;
      if (gnt_vld !== 1'b1 || gnt_idx !== 2'd1 || gnt_oht !== 4'b0010 || gnt_dat !== 8'h5A || req_rdy !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL stall_hold s=%0d: got vld=%b idx=%0d oht=%b dat=%h rdy=%b expected 1/1/0010/5a/0000",
                 s, gnt_vld, gnt_idx, gnt_oht, gnt_dat, req_rdy);
      end
      if (s == 1) req_vld = 4'b0011;
      tick();
    end
    gnt_rdy = 1'b1;
    settle();
    checks++;
    if (req_rdy !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL stall_release_rdy: got %b expected 0010", req_rdy);
    end
    tick();
    req_vld = 4'b0001;
    settle();
    checks++;
    if (gnt_vld !== 1'b1 || gnt_idx !== 2'd0 || gnt_dat !== 8'h3C) begin
      errors++;
      $display("[TB] FAIL stall_next_grant: got vld=%b idx=%0d dat=%h expected 1/0/3c", gnt_vld, gnt_idx, gnt_dat);
    end
    tick();
    req_vld = 4'b0000;
    settle();
    checks++;
    if (gnt_vld !== 1'b0 || gnt_oht !== 4'b0000 || gnt_idx !== 2'd0 || gnt_dat !== 8'h3C) begin
      errors++;
      $display("[TB] FAIL drain_empty: got vld=%b oht=%b idx=%0d dat=%h expected 0/0000/0/3c",
               gnt_vld, gnt_oht, gnt_idx, gnt_dat);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req_vld    = 4'b1000;
    req_dat[3] = 8'hD3;
    gnt_rdy    = 1'b1;
    tick();
    req_vld    = 4'b1010;
    req_dat[1] = 8'hB1;
    settle();
    checks++;
    if (gnt_idx !== 2'd3 || gnt_dat !== 8'hD3) begin
      errors++;
      $display("[TB] FAIL wrap_start: got idx=%0d dat=%h expected 3/d3", gnt_idx, gnt_dat);
    end
    tick();
    req_dat[3] = 8'hD4;
    settle();
    checks++;
    if (gnt_vld !== 1'b1 || gnt_idx !== 2'd1 || gnt_oht !== 4'b0010 || gnt_dat !== 8'hB1) begin
      errors++;
      $display("[TB] FAIL wrap_to_1: got vld=%b idx=%0d oht=%b dat=%h expected 1/1/0010/b1",
               gnt_vld, gnt_idx, gnt_oht, gnt_dat);
    end
    tick();
    req_vld = 4'b1000;
    settle();
    checks++;
    if (gnt_vld !== 1'b1 || gnt_idx !== 2'd3 || gnt_dat !== 8'hD4) begin
      errors++;
      $display("[TB] FAIL wrap_then_3: got vld=%b idx=%0d dat=%h expected 1/3/d4", gnt_vld, gnt_idx, gnt_dat);
    end
    tick();
    req_vld = 4'b0000;
  endtask

  task automatic test_sole_requester();
    logic [7:0] dats [3];
    dats[0] = 8'hA0;
    dats[1] = 8'hA1;
    dats[2] = 8'hA2;
    do_reset();
    req_vld    = 4'b0100;
    req_dat[2] = dats[0];
    gnt_rdy    = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      settle();
      checks++;
      if (gnt_vld !== 1'b1 || gnt_idx !== 2'd2 || gnt_dat !== dats[n]) begin
        errors++;
        $display("[TB] FAIL sole_grant n=%0d: got vld=%b idx=%0d dat=%h expected 1/2/%h",
                 n, gnt_vld, gnt_idx, gnt_dat, dats[n]);
      end
      tick();
      if (n < 2) req_dat[2] = dats[n+1];
      else req_vld = 4'b0000;
      settle();
      checks++;
      if (gnt_vld !== 1'b0) begin
        errors++;
        $display("[TB] FAIL sole_bubble n=%0d: got vld=%b expected 0", n, gnt_vld);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_vld    = 4'b0100;
    req_dat[2] = 8'hE2;
    req_dat[0] = 8'hE0;
    gnt_rdy    = 1'b0;
    tick();
    req_vld = 4'b0101;
    rst     = 1'b1;
    settle();
    checks++;
    if (gnt_vld !== 1'b1 || gnt_idx !== 2'd2 || req_rdy !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL midrst_before: got vld=%b idx=%0d rdy=%b expected 1/2/0000", gnt_vld, gnt_idx, req_rdy);
    end
    tick();
    rst = 1'b0;
    settle();
    checks++;
    if (gnt_vld !== 1'b0 || gnt_oht !== 4'b0000 || gnt_idx !== 2'd0 || gnt_dat !== 8'h00 || req_rdy !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL midrst_cleared: got vld=%b oht=%b idx=%0d dat=%h rdy=%b expected 0/0000/0/00/0000",
               gnt_vld, gnt_oht, gnt_idx, gnt_dat, req_rdy);
    end
    gnt_rdy = 1'b1;
    tick();
    settle();
    checks++;
    if (gnt_vld !== 1'b1 || gnt_idx !== 2'd0 || gnt_dat !== 8'hE0 || req_rdy !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL midrst_grant0: got vld=%b idx=%0d dat=%h rdy=%b expected 1/0/e0/0001",
               gnt_vld, gnt_idx, gnt_dat, req_rdy);
    end
    tick();
    req_vld = 4'b0100;
    settle();
    checks++;
    if (gnt_vld !== 1'b1 || gnt_idx !== 2'd2 || gnt_dat !== 8'hE2) begin
      errors++;
      $display("[TB] FAIL midrst_grant2: got vld=%b idx=%0d dat=%h expected 1/2/e2", gnt_vld, gnt_idx, gnt_dat);
    end
    tick();
    req_vld = 4'b0000;
    settle();
    checks++;
    if (gnt_vld !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_drain: got vld=%b expected 0", gnt_vld);
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    rst     = 1'b1;
    req_vld = 4'b0000;
    gnt_rdy = 1'b0;
    for (int i = 0; i < 4; i++) req_dat[i] = 8'h00;
    $display("[TB] starting rr_arbiter_thr bench");
    test_reset();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_sole_requester();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
